mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL expose `rst`, input, 1 bit: synchronous, active-low reset, sampled only on the `clk` rising edge.
REQ-003 The block SHALL expose `op`, `func3` and `func7`, inputs of 7, 3 and 7 bits: instruction fields taken from the instruction register.
REQ-004 The block SHALL expose `zero`, input, 1 bit: ALU zero flag.
REQ-005 The block SHALL expose `mem_ready`, input, 1 bit: the unified memory has completed the current access.
REQ-006 The block SHALL expose `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` and `AdrSrc`, outputs, 1 bit each.
- `AdrSrc`: 0 = PC, 1 = ALUOut.
REQ-007 The block SHALL expose `ALUSrcA`, output, 2 bits: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-008 The block SHALL expose `ALUSrcB`, output, 2 bits: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-009 The block SHALL expose `ResultSrc`, output, 2 bits: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-010 The block SHALL expose `ImmSrc`, output, 2 bits: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-011 The block SHALL expose `ALUControl`, output, 3 bits: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 The block SHALL expose `state`, output, 4 bits: current state encoding, for debug only.
REQ-013 The block SHALL expose `illegal`, output, 1 bit: an unsupported opcode was decoded.

Function
REQ-014 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL and TRAP, with one registered state and Moore outputs except `PCWrite`.
REQ-015 In FETCH the block SHALL drive `AdrSrc` = 0, `ALUSrcA` = 00, `ALUSrcB` = 10, ALUOp = add and `ResultSrc` = 10.
- While `mem_ready` = 0: the FSM stays in FETCH with `IRWrite` = 0 and `PCWrite` = 0.
- When `mem_ready` = 1: `IRWrite` = 1 and `PCWrite` = 1 for exactly that cycle, then the next state is DECODE.
REQ-016 In DECODE the block SHALL drive `ALUSrcA` = 01, `ALUSrcB` = 01 and add, and select the next state from `op`:
- 0000011 or 0100011 → MEMADR
- 0110011 → EXECUTER
- 0010011 → EXECUTEI
- 1100011 → BEQ
- 1101111 → JAL
- any other value → TRAP
REQ-017 In MEMADR the block SHALL drive `ALUSrcA` = 10, `ALUSrcB` = 01 and add, then go to MEMREAD when `op` = 0000011, else to MEMWRITE.
REQ-018 In MEMREAD the block SHALL drive `ResultSrc` = 00 and `AdrSrc` = 1, and hold until `mem_ready` = 1, then go to MEMWB.
REQ-019 In MEMWB the block SHALL drive `ResultSrc` = 01 and `RegWrite` = 1, then go to FETCH.
REQ-020 In MEMWRITE the block SHALL drive `ResultSrc` = 00, `AdrSrc` = 1 and `MemWrite` = 1 each cycle until `mem_ready` = 1, then go to FETCH.
REQ-021 In EXECUTER and EXECUTEI the block SHALL drive `ALUSrcA` = 10 and ALUOp = funct, with `ALUSrcB` = 00 in EXECUTER and 01 in EXECUTEI, then go to ALUWB.
REQ-022 In ALUWB the block SHALL drive `ResultSrc` = 00 and `RegWrite` = 1, then go to FETCH.
REQ-023 In BEQ the block SHALL drive `ALUSrcA` = 10, `ALUSrcB` = 00, sub and `ResultSrc` = 00, set `PCWrite` = `zero` combinationally, then go to FETCH.
REQ-024 JAL SHALL take two cycles:
- Cycle 1: `ALUSrcA` = 01, `ALUSrcB` = 10, add, `ResultSrc` = 00, `PCWrite` = 1.
- Cycle 2 (through ALUWB): write the return address.
REQ-025 TRAP SHALL be absorbing: `illegal` = 1 and every write enable 0 until reset.
REQ-026 ALU decode SHALL produce:
- ALUOp add → 000; ALUOp sub → 001.
- ALUOp funct → by `func3`: 000 → sub only when `op[5]` = 1 and `func7[5]` = 1, else add; 010 → slt; 110 → or; 111 → and; others → add.
REQ-027 `ImmSrc` SHALL be decoded from `op` in every state (lw/I → 00, sw → 01, beq → 10, jal → 11, other → 00).
REQ-028 Any write enable that is not explicitly asserted in a state SHALL be 0 in that state.

Reset
REQ-029 When `rst` = 0 at a rising edge, the next state SHALL be FETCH regardless of the current state, including mid-access waits and TRAP.
REQ-030 During reset, `PCWrite`, `IRWrite`, `RegWrite` and `MemWrite` SHALL be 0, `illegal` SHALL be 0, and `state` SHALL read FETCH.
REQ-031 The first FETCH after reset release SHALL begin on the cycle `rst` returns to 1.

Structure
REQ-032 The state encodings, ALUOp codes, ALUControl codes, opcode constants and the mux-select codes SHALL live in a shared package `mc_pkg`.
REQ-033 The ALU decode SHALL be one sub-module, `mc_alu_decoder`, and the FSM plus the Moore output table SHALL stay in `mc_controller`.

Verification
REQ-034 lw with `mem_ready` held at 1: FETCH→DECODE→MEMADR→MEMREAD→MEMWB, 5 cycles, with `RegWrite` = 1 only in cycle 5 and `ResultSrc` = 01.
REQ-035 sw with `mem_ready` = 0 for 3 cycles in MEMWRITE: `MemWrite` = 1 for 4 cycles, then FETCH, with no `RegWrite`.
REQ-036 R-type with `func3` = 000 and `func7` = 0100000: `ALUControl` = 001 in EXECUTER, then ALUWB `RegWrite` = 1; with `func7` = 0, `ALUControl` = 000.
REQ-037 beq with `zero` = 1: `PCWrite` = 1 in BEQ; with `zero` = 0: `PCWrite` = 0; both return to FETCH.
REQ-038 `op` = 1111111: TRAP is entered, `illegal` = 1 and write enables stay 0 for 10 cycles; `rst` = 0 for one cycle returns to FETCH with `illegal` = 0.
REQ-039 Reset asserted in MEMREAD while `mem_ready` = 0: the next state is FETCH, with no `RegWrite` or `MemWrite` pulse.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RISC-V controller.
// Holds the FSM state encoding, ALUOp and ALUControl codes, the
// supported opcodes, the datapath mux-select codes and the
// immediate-format decode helper.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on the state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode for the multi-cycle controller.
// Ports:
//   alu_op      - ALUOp from the FSM (add / sub / funct)
//   func3       - instruction funct3 field
//   op5         - opcode bit 5 (distinguishes R-type from I-type)
//   func7_5     - funct7 bit 5 (sub vs add for R-type)
//   alu_control - 3-bit ALU operation select
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] func3,
  input  logic       op5,
  input  logic       func7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (func3)
          // addi never subtracts, so funct7 only matters for R-type.
          3'b000:  alu_control = (op5 && func7_5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  alu_control = ALUC_SLT;
          3'b110:  alu_control = ALUC_OR;
          3'b111:  alu_control = ALUC_AND;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RISC-V (lw/sw/R/I/beq/jal) control unit.
// Ports:
//   clk, rst           - rising-edge clock, synchronous active-low reset
//   op, func3, func7   - instruction register fields
//   zero               - ALU zero flag (branch decision)
//   mem_ready          - unified memory finished the current access
//   PCWrite, IRWrite, RegWrite, MemWrite - write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl - datapath selects
//   state              - current state (debug)
//   illegal            - unsupported opcode trapped
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state,
  output logic       illegal
);

  state_t  cur_state;
  state_t  view_state;
  alu_op_t alu_op;
  logic    unused_func7;

  // Only funct7[5] takes part in decode.
  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state <= S_FETCH;
    end else begin
      case (cur_state)
        S_FETCH:    if (mem_ready) cur_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: cur_state <= S_MEMADR;
            OP_RTYPE:     cur_state <= S_EXECUTER;
            OP_ITYPE:     cur_state <= S_EXECUTEI;
            OP_BEQ:       cur_state <= S_BEQ;
            OP_JAL:       cur_state <= S_JAL;
            default:      cur_state <= S_TRAP;
          endcase
        end
        S_MEMADR:   cur_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) cur_state <= S_MEMWB;
        S_MEMWB:    cur_state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) cur_state <= S_FETCH;
        S_EXECUTER: cur_state <= S_ALUWB;
        S_EXECUTEI: cur_state <= S_ALUWB;
        S_ALUWB:    cur_state <= S_FETCH;
        S_BEQ:      cur_state <= S_FETCH;
        S_JAL:      cur_state <= S_ALUWB;
        S_TRAP:     cur_state <= S_TRAP;
        default:    cur_state <= S_FETCH;
      endcase
    end
  end

  // While reset is held the outputs already present FETCH, so nothing
  // downstream sees a stale state (e.g. an interrupted MEMREAD).
  assign view_state = rst ? cur_state : S_FETCH;
  assign state      = view_state;
  assign ImmSrc     = imm_src_of(op);

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    alu_op    = ALUOP_ADD;
    illegal   = 1'b0;
    case (view_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        PCWrite = zero;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_TRAP:     illegal = 1'b1;
      default: ;
    endcase
    if (!rst) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
    end
  end

  mc_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .func3       (func3),
    .op5         (op[5]),
    .func7_5     (func7[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a table of per-cycle stimulus
// and expected outputs plus hand-written multi-cycle sequences. Each
// driven cycle pushes its expectation onto a queue that a negedge
// monitor pops and compares.
module tb_mc_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [6:0] F7S = 7'b0100000;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, adr;
    logic [1:0] sa, sb, rs, imm;
    logic [2:0] aluc;
    logic       ill;
  } exp_t;

  typedef struct {
    string      nm;
    logic       r;
    logic [6:0] o;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z, m;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [6:0] op, func7;
  logic [2:0] func3;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  string nm_q[$];
  int    step_no = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .state(state), .illegal(illegal)
  );

  // mk(state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
  //    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal)
  function automatic exp_t mk(int st, int pcw, int irw, int rw, int mw, int adr,
                              int sa, int sb, int rs, int imm, int aluc, int ill);
    exp_t e;
    e.st = 4'(st); e.pcw = 1'(pcw); e.irw = 1'(irw); e.rw = 1'(rw);
    e.mw = 1'(mw); e.adr = 1'(adr); e.sa = 2'(sa); e.sb = 2'(sb);
    e.rs = 2'(rs); e.imm = 2'(imm); e.aluc = 3'(aluc); e.ill = 1'(ill);
    return e;
  endfunction

  function automatic vec_t v(string nm, int r, logic [6:0] o, logic [2:0] f3,
                             logic [6:0] f7, int z, int m, exp_t e);
    vec_t x;
    x.nm = nm; x.r = 1'(r); x.o = o; x.f3 = f3; x.f7 = f7;
    x.z = 1'(z); x.m = 1'(m); x.e = e;
    return x;
  endfunction

  task automatic step(input vec_t x);
    rst = x.r; op = x.o; func3 = x.f3; func7 = x.f7;
    zero = x.z; mem_ready = x.m;
    exp_q.push_back(x.e);
    nm_q.push_back(x.nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = {state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got st=%0d we=%b sel=%b_%b_%b_%b_%b alu=%b ill=%b, want st=%0d we=%b sel=%b_%b_%b_%b_%b alu=%b ill=%b",
                 n, step_no, a.st, {a.pcw, a.irw, a.rw, a.mw}, a.adr, a.sa, a.sb, a.rs, a.imm,
                 a.aluc, a.ill, e.st, {e.pcw, e.irw, e.rw, e.mw}, e.adr, e.sa, e.sb, e.rs,
                 e.imm, e.aluc, e.ill);
      end
      step_no++;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    rst = 1'b0; op = LW; func3 = 3'b000; func7 = 7'b0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset: enables gated even with mem_ready high.
    tbl.push_back(v("reset", 0, LW, 3'b010, 0, 0, 1, mk(0,0,0,0,0,0,0,2,2,0,0,0)));
    tbl.push_back(v("reset", 0, LW, 3'b010, 0, 0, 1, mk(0,0,0,0,0,0,0,2,2,0,0,0)));
    // lw, mem_ready always 1: five cycles, RegWrite only in MEMWB.
    tbl.push_back(v("lw_fetch",  1, LW, 3'b010, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    tbl.push_back(v("lw_decode", 1, LW, 3'b010, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));
    tbl.push_back(v("lw_memadr", 1, LW, 3'b010, 0, 0, 1, mk(2,0,0,0,0,0,2,1,0,0,0,0)));
    tbl.push_back(v("lw_memrd",  1, LW, 3'b010, 0, 0, 1, mk(3,0,0,0,0,1,0,0,0,0,0,0)));
    tbl.push_back(v("lw_memwb",  1, LW, 3'b010, 0, 0, 1, mk(4,0,0,1,0,0,0,0,1,0,0,0)));
    // R-type sub (funct7=0100000).
    tbl.push_back(v("sub_fetch", 1, RT, 3'b000, F7S, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    tbl.push_back(v("sub_dec",   1, RT, 3'b000, F7S, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));
    tbl.push_back(v("sub_exec",  1, RT, 3'b000, F7S, 0, 1, mk(6,0,0,0,0,0,2,0,0,0,1,0)));
    tbl.push_back(v("sub_wb",    1, RT, 3'b000, F7S, 0, 1, mk(8,0,0,1,0,0,0,0,0,0,0,0)));
    // R-type add (funct7=0).
    tbl.push_back(v("add_fetch", 1, RT, 3'b000, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    tbl.push_back(v("add_dec",   1, RT, 3'b000, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));
    tbl.push_back(v("add_exec",  1, RT, 3'b000, 0, 0, 1, mk(6,0,0,0,0,0,2,0,0,0,0,0)));
    tbl.push_back(v("add_wb",    1, RT, 3'b000, 0, 0, 1, mk(8,0,0,1,0,0,0,0,0,0,0,0)));
    // addi with funct7[5]=1 must still add (op[5]=0).
    tbl.push_back(v("addi_fetch", 1, IT, 3'b000, F7S, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    tbl.push_back(v("addi_dec",   1, IT, 3'b000, F7S, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));
    tbl.push_back(v("addi_exec",  1, IT, 3'b000, F7S, 0, 1, mk(7,0,0,0,0,0,2,1,0,0,0,0)));
    tbl.push_back(v("addi_wb",    1, IT, 3'b000, F7S, 0, 1, mk(8,0,0,1,0,0,0,0,0,0,0,0)));
    // slti -> slt.
    tbl.push_back(v("slti_fetch", 1, IT, 3'b010, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    tbl.push_back(v("slti_dec",   1, IT, 3'b010, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));
    tbl.push_back(v("slti_exec",  1, IT, 3'b010, 0, 0, 1, mk(7,0,0,0,0,0,2,1,0,0,5,0)));
    tbl.push_back(v("slti_wb",    1, IT, 3'b010, 0, 0, 1, mk(8,0,0,1,0,0,0,0,0,0,0,0)));
    // and / or.
    tbl.push_back(v("and_fetch", 1, RT, 3'b111, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    tbl.push_back(v("and_dec",   1, RT, 3'b111, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));
    tbl.push_back(v("and_exec",  1, RT, 3'b111, 0, 0, 1, mk(6,0,0,0,0,0,2,0,0,0,2,0)));
    tbl.push_back(v("and_wb",    1, RT, 3'b111, 0, 0, 1, mk(8,0,0,1,0,0,0,0,0,0,0,0)));
    tbl.push_back(v("or_fetch",  1, RT, 3'b110, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    tbl.push_back(v("or_dec",    1, RT, 3'b110, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));
    tbl.push_back(v("or_exec",   1, RT, 3'b110, 0, 0, 1, mk(6,0,0,0,0,0,2,0,0,0,3,0)));
    tbl.push_back(v("or_wb",     1, RT, 3'b110, 0, 0, 1, mk(8,0,0,1,0,0,0,0,0,0,0,0)));
    // beq taken / not taken.
    tbl.push_back(v("beq1_fetch", 1, BQ, 3'b000, 0, 1, 1, mk(0,1,1,0,0,0,0,2,2,2,0,0)));
    tbl.push_back(v("beq1_dec",   1, BQ, 3'b000, 0, 1, 1, mk(1,0,0,0,0,0,1,1,0,2,0,0)));
    tbl.push_back(v("beq1_beq",   1, BQ, 3'b000, 0, 1, 1, mk(9,1,0,0,0,0,2,0,0,2,1,0)));
    tbl.push_back(v("beq0_fetch", 1, BQ, 3'b000, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,2,0,0)));
    tbl.push_back(v("beq0_dec",   1, BQ, 3'b000, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,2,0,0)));
    tbl.push_back(v("beq0_beq",   1, BQ, 3'b000, 0, 0, 1, mk(9,0,0,0,0,0,2,0,0,2,1,0)));
    // jal: JAL then ALUWB.
    tbl.push_back(v("jal_fetch", 1, JL, 3'b000, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,3,0,0)));
    tbl.push_back(v("jal_dec",   1, JL, 3'b000, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,3,0,0)));
    tbl.push_back(v("jal_jal",   1, JL, 3'b000, 0, 0, 1, mk(10,1,0,0,0,0,1,2,0,3,0,0)));
    tbl.push_back(v("jal_wb",    1, JL, 3'b000, 0, 0, 1, mk(8,0,0,1,0,0,0,0,0,3,0,0)));
    // FETCH waiting on memory.
    tbl.push_back(v("fetch_wait", 1, SW, 3'b010, 0, 0, 0, mk(0,0,0,0,0,0,0,2,2,1,0,0)));
    tbl.push_back(v("fetch_wait", 1, SW, 3'b010, 0, 0, 0, mk(0,0,0,0,0,0,0,2,2,1,0,0)));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    checks++;
    if (state !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hold: got st=%0d irw=%b pcw=%b, want st=0 irw=0 pcw=0",
               state, IRWrite, PCWrite);
    end

    // sw with three wait cycles in MEMWRITE: MemWrite held four cycles.
    step(v("sw_fetch",  1, SW, 3'b010, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,1,0,0)));
    step(v("sw_dec",    1, SW, 3'b010, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,1,0,0)));
    step(v("sw_memadr", 1, SW, 3'b010, 0, 0, 1, mk(2,0,0,0,0,0,2,1,0,1,0,0)));
    for (int i = 0; i < 3; i++)
      step(v("sw_memwr_wait", 1, SW, 3'b010, 0, 0, 0, mk(5,0,0,0,1,1,0,0,0,1,0,0)));
    step(v("sw_memwr_done", 1, SW, 3'b010, 0, 0, 1, mk(5,0,0,0,1,1,0,0,0,1,0,0)));
    step(v("sw_back_fetch", 1, SW, 3'b010, 0, 0, 0, mk(0,0,0,0,0,0,0,2,2,1,0,0)));

    checks++;
    if (state !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL sw_end: got st=%0d rw=%b mw=%b, want st=0 rw=0 mw=0",
               state, RegWrite, MemWrite);
    end

    // Reset while MEMREAD waits on memory: straight to FETCH, no write pulse.
    step(v("lwr_fetch",  1, LW, 3'b010, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    step(v("lwr_dec",    1, LW, 3'b010, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));
    step(v("lwr_memadr", 1, LW, 3'b010, 0, 0, 1, mk(2,0,0,0,0,0,2,1,0,0,0,0)));
    step(v("lwr_memrd",  1, LW, 3'b010, 0, 0, 0, mk(3,0,0,0,0,1,0,0,0,0,0,0)));
    step(v("lwr_memrd",  1, LW, 3'b010, 0, 0, 0, mk(3,0,0,0,0,1,0,0,0,0,0,0)));
    step(v("lwr_rst",    0, LW, 3'b010, 0, 0, 0, mk(0,0,0,0,0,0,0,2,2,0,0,0)));

    checks++;
    if (state !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL lwr_state: got st=%0d rw=%b mw=%b, want st=0 rw=0 mw=0",
               state, RegWrite, MemWrite);
    end

    step(v("lwr_after",  1, LW, 3'b010, 0, 0, 0, mk(0,0,0,0,0,0,0,2,2,0,0,0)));

    // Unsupported opcode: TRAP absorbs for 10 cycles, one reset cycle exits.
    step(v("trap_fetch", 1, BAD, 3'b000, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    step(v("trap_dec",   1, BAD, 3'b000, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));

    checks++;
    if (state !== 4'd11 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL trap_enter: got st=%0d ill=%b, want st=11 ill=1", state, illegal);
    end

    for (int i = 0; i < 10; i++)
      step(v("trap_hold", 1, BAD, 3'b000, 0, 1, 1, mk(11,0,0,0,0,0,0,0,0,0,0,1)));
    step(v("trap_rst",   0, BAD, 3'b000, 0, 1, 1, mk(0,0,0,0,0,0,0,2,2,0,0,0)));

    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL trap_exit: got st=%0d ill=%b, want st=0 ill=0", state, illegal);
    end

    step(v("trap_after", 1, LW, 3'b010, 0, 0, 0, mk(0,0,0,0,0,0,0,2,2,0,0,0)));
    step(v("trap_run",   1, LW, 3'b010, 0, 0, 1, mk(0,1,1,0,0,0,0,2,2,0,0,0)));
    step(v("trap_run",   1, LW, 3'b010, 0, 0, 1, mk(1,0,0,0,0,0,1,1,0,0,0,0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
